// File: rtl/host_csr_pkg.sv
// Purpose: shared FSM state type, address-map offsets and a byte-lane helper for the host CSR bank.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package host_csr_pkg;

    typedef enum logic [0:0] {
        e_ready = 1'b0,
        e_resp  = 1'b1
    } state_e;

    // Word offsets of the non-CSR slots, counted from num_regs_p.
    localparam int out_fifo_ofs_lp = 0;
    localparam int in_fifo_ofs_lp  = 1;
    localparam int status_ofs_lp   = 2;

    // True when byte b lies in [lane, lane+nbytes); the caller clips to the word.
    function automatic logic lane_hit(input int b, input int lane, input int nbytes);
        return (b >= lane) && (b < lane + nbytes);
    endfunction

endpackage

// File: rtl/host_csr_if.sv
// Purpose: generic valid/ready-and data channel used for the FIFO enqueue/dequeue sides.
// Latency: n/a (wires only).
// Backpressure: producer holds v/data until ready_and is seen high at a clock edge.
// Ports: v, data driven by master; ready_and driven by slave.
interface host_csr_if #(
    parameter int width_p = 32
);
    logic               v;
    logic               ready_and;
    logic [width_p-1:0] data;

    modport master (output v, output data, input  ready_and);
    modport slave  (input  v, input  data, output ready_and);
endinterface

// File: rtl/host_csr_fifo.sv
// Purpose: small circular-buffer FIFO with occupancy count.
// Latency: one cycle from push to dequeue-visible; pop takes effect at the edge.
// Backpressure: enq.ready_and low only while full (a same-cycle pop does not free a slot).
// Ports: clk_i, reset_n_i (async active-low), enq (slave), deq (master), count_o 0..els_p.
module host_csr_fifo #(
    parameter int width_p = 32,
    parameter int els_p   = 4,
    localparam int cnt_w_lp = $clog2(els_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    host_csr_if.slave           enq,
    host_csr_if.master          deq,
    output logic [cnt_w_lp-1:0] count_o
);
    localparam int ptr_w_lp = $clog2(els_p);

    if (els_p < 2 || els_p > 16 || (els_p & (els_p - 1)) != 0) begin : g_bad_els
        $fatal(1, "host_csr_fifo: els_p must be a power of 2 in 2..16");
    end

    logic [width_p-1:0]  mem_q [els_p];
    logic [width_p-1:0]  mem_d [els_p];
    logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
    logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic                not_full, not_empty, push, pop;

    assign not_full      = (count_q != cnt_w_lp'(els_p));
    assign not_empty     = (count_q != '0);
    assign enq.ready_and = not_full;
    assign deq.v         = not_empty;
    assign deq.data      = mem_q[rd_ptr_q];
    assign push          = enq.v & not_full;
    assign pop           = not_empty & deq.ready_and;
    assign count_o       = count_q;

    // Pointers wrap naturally since els_p is a power of 2.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = enq.data;
            wr_ptr_d        = wr_ptr_q + ptr_w_lp'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + cnt_w_lp'(1);
            2'b01:   count_d = count_q - cnt_w_lp'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/host_csr_bank.sv
// Purpose: host-addressed bank of R/W CSRs plus an outbound FIFO, an inbound FIFO and a status word.
// Latency: request accepted at edge N, response valid from the cycle after N; one request in flight.
// Backpressure: ready_and_o low while a response is pending or for a write to a full OUT FIFO.
// Ports: clk_i, reset_n_i; host request (v_i/ready_and_o/addr_i/wr_en_i/data_size_i/wdata_i);
//        response (v_o/ready_and_i/rdata_o); csr_o flattened CSRs; out_* FIFO drain; in_* FIFO fill.
module host_csr_bank
    import host_csr_pkg::*;
#(
    parameter int data_width_p = 32,
    parameter int addr_width_p = 32,
    parameter int num_regs_p   = 4,
    parameter int fifo_els_p   = 4
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               v_i,
    output logic                               ready_and_o,
    input  logic [addr_width_p-1:0]            addr_i,
    input  logic                               wr_en_i,
    input  logic [1:0]                         data_size_i,
    input  logic [data_width_p-1:0]            wdata_i,
    output logic                               v_o,
    input  logic                               ready_and_i,
    output logic [data_width_p-1:0]            rdata_o,
    output logic [num_regs_p*data_width_p-1:0] csr_o,
    output logic                               out_v_o,
    output logic [data_width_p-1:0]            out_data_o,
    input  logic                               out_ready_and_i,
    input  logic                               in_v_i,
    input  logic [data_width_p-1:0]            in_data_i,
    output logic                               in_ready_and_o
);
    localparam int bytes_lp = data_width_p / 8;
    localparam int lsb_lp   = $clog2(bytes_lp);
    localparam int idx_w_lp = addr_width_p - lsb_lp;
    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);

    if (data_width_p != 32 && data_width_p != 64) begin : g_bad_dw
        $fatal(1, "host_csr_bank: data_width_p must be 32 or 64");
    end
    if (num_regs_p < 1 || num_regs_p > 16) begin : g_bad_regs
        $fatal(1, "host_csr_bank: num_regs_p must be in 1..16");
    end

    state_e                  state_q, state_d;
    logic [data_width_p-1:0] rdata_q, rdata_d;
    logic [data_width_p-1:0] csr_q [num_regs_p];
    logic [data_width_p-1:0] csr_d [num_regs_p];

    logic [idx_w_lp-1:0]     word_idx;
    logic [lsb_lp-1:0]       lane;
    logic [3:0]              nbytes;
    logic [data_width_p-1:0] wdata_shift;
    logic [data_width_p-1:0] rd_word;
    logic                    hit_csr, hit_out, hit_in, hit_status;
    logic                    push_out, pop_in;
    logic [cnt_w_lp-1:0]     out_cnt, in_cnt;

    host_csr_if #(.width_p(data_width_p)) out_enq_if ();
    host_csr_if #(.width_p(data_width_p)) out_deq_if ();
    host_csr_if #(.width_p(data_width_p)) in_enq_if ();
    host_csr_if #(.width_p(data_width_p)) in_deq_if ();

    host_csr_fifo #(.width_p(data_width_p), .els_p(fifo_els_p)) u_out_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .enq       (out_enq_if),
        .deq       (out_deq_if),
        .count_o   (out_cnt)
    );

    host_csr_fifo #(.width_p(data_width_p), .els_p(fifo_els_p)) u_in_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .enq       (in_enq_if),
        .deq       (in_deq_if),
        .count_o   (in_cnt)
    );

    assign out_enq_if.v         = push_out;
    assign out_enq_if.data      = wdata_i;
    assign out_deq_if.ready_and = out_ready_and_i;
    assign out_v_o              = out_deq_if.v;
    assign out_data_o           = out_deq_if.data;

    assign in_enq_if.v          = in_v_i;
    assign in_enq_if.data       = in_data_i;
    assign in_ready_and_o       = in_enq_if.ready_and;
    assign in_deq_if.ready_and  = pop_in;

    // Address decode: low bits pick the starting byte lane for CSR writes.
    assign word_idx    = addr_i[addr_width_p-1:lsb_lp];
    assign lane        = addr_i[lsb_lp-1:0];
    assign nbytes      = 4'd1 << data_size_i;
    assign wdata_shift = wdata_i << {lane, 3'b000};
    assign hit_csr     = (word_idx < idx_w_lp'(num_regs_p));
    assign hit_out     = (word_idx == idx_w_lp'(num_regs_p + out_fifo_ofs_lp));
    assign hit_in      = (word_idx == idx_w_lp'(num_regs_p + in_fifo_ofs_lp));
    assign hit_status  = (word_idx == idx_w_lp'(num_regs_p + status_ofs_lp));

    always_comb begin
        rd_word = '0;
        if (hit_csr) begin
            for (int r = 0; r < num_regs_p; r++) begin
                if (word_idx == idx_w_lp'(r)) begin
                    rd_word = csr_q[r];
                end
            end
        end else if (hit_in) begin
            // An empty IN FIFO reads as zero; the pop itself is gated below.
            if (in_deq_if.v) begin
                rd_word = in_deq_if.data;
            end
        end else if (hit_status) begin
            rd_word[15:0] = {8'(in_cnt), 8'(out_cnt)};
        end
    end

    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        csr_d       = csr_q;
        push_out    = 1'b0;
        pop_in      = 1'b0;
        ready_and_o = 1'b0;
        case (state_q)
            e_ready: begin
                ready_and_o = reset_n_i &&
                              !(v_i && wr_en_i && hit_out && !out_enq_if.ready_and);
                if (v_i && ready_and_o) begin
                    state_d = e_resp;
                    if (wr_en_i) begin
                        rdata_d  = '0;
                        push_out = hit_out;
                        if (hit_csr) begin
                            for (int r = 0; r < num_regs_p; r++) begin
                                if (word_idx == idx_w_lp'(r)) begin
                                    for (int b = 0; b < bytes_lp; b++) begin
                                        if (lane_hit(b, int'(lane), int'(nbytes))) begin
                                            csr_d[r][b*8 +: 8] = wdata_shift[b*8 +: 8];
                                        end
                                    end
                                end
                            end
                        end
                    end else begin
                        rdata_d = rd_word;
                        pop_in  = hit_in && in_deq_if.v;
                    end
                end
            end
            e_resp: begin
                if (ready_and_i) begin
                    state_d = e_ready;
                end
            end
            default: state_d = e_ready;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_ready;
            rdata_q <= '0;
            for (int r = 0; r < num_regs_p; r++) begin
                csr_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            csr_q   <= csr_d;
        end
    end

    assign v_o     = (state_q == e_resp);
    assign rdata_o = rdata_q;

    for (genvar g = 0; g < num_regs_p; g++) begin : g_csr_o
        assign csr_o[g*data_width_p +: data_width_p] = csr_q[g];
    end

endmodule

// File: tb/tb_host_csr_bank.sv
// Purpose: self-checking bench for host_csr_bank with default parameters (32-bit, 4 CSRs, depth-4 FIFOs).
// Latency: expected read data queued at request acceptance, compared when the response is consumed.
// Backpressure: exercises full OUT FIFO, full IN FIFO, stalled response and reset during a response.
module tb_host_csr_bank;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         v_i = 1'b0;
    logic         ready_and_o;
    logic [31:0]  addr_i = '0;
    logic         wr_en_i = 1'b0;
    logic [1:0]   data_size_i = 2'b10;
    logic [31:0]  wdata_i = '0;
    logic         v_o;
    logic         ready_and_i = 1'b1;
    logic [31:0]  rdata_o;
    logic [127:0] csr_o;
    logic         out_v_o;
    logic [31:0]  out_data_o;
    logic         out_ready_and_i = 1'b0;

    host_csr_if #(.width_p(32)) in_if ();

    host_csr_bank dut (
        .clk_i           (clk),
        .reset_n_i       (rst_n),
        .v_i             (v_i),
        .ready_and_o     (ready_and_o),
        .addr_i          (addr_i),
        .wr_en_i         (wr_en_i),
        .data_size_i     (data_size_i),
        .wdata_i         (wdata_i),
        .v_o             (v_o),
        .ready_and_i     (ready_and_i),
        .rdata_o         (rdata_o),
        .csr_o           (csr_o),
        .out_v_o         (out_v_o),
        .out_data_o      (out_data_o),
        .out_ready_and_i (out_ready_and_i),
        .in_v_i          (in_if.v),
        .in_data_i       (in_if.data),
        .in_ready_and_o  (in_if.ready_and)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Response monitor: compares each consumed response against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && v_o && ready_and_i) begin
            if (exp_q.size() == 0) begin
                chk("resp_without_req", 64'(exp_q.size()), 64'h1);
            end else begin
                chk(tag_q.pop_front(), 64'(rdata_o), 64'(exp_q.pop_front()));
            end
        end
    end

    // Drives one host request and returns just after it is accepted.
    task automatic req(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] wd, input logic [31:0] exp, input string tag);
        int cyc = 0;
        @(negedge clk);
        v_i = 1'b1; wr_en_i = wr; addr_i = a; data_size_i = sz; wdata_i = wd;
        #1;
        while (!ready_and_o && cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (!ready_and_o) begin
            chk({tag, "_accept_timeout"}, 64'(ready_and_o), 64'h1);
            v_i = 1'b0;
            return;
        end
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        v_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        chk({tag, "_pending"}, 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        in_if.v = 1'b0;
        in_if.data = '0;

        // Reset state, with a request presented to prove the ready gating.
        v_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready_and", 64'(ready_and_o), 64'h0);
        chk("rst_v_o", 64'(v_o), 64'h0);
        chk("rst_rdata", 64'(rdata_o), 64'h0);
        chk("rst_out_v", 64'(out_v_o), 64'h0);
        chk("rst_in_ready", 64'(in_if.ready_and), 64'h1);
        chk("rst_csr", 64'(|csr_o), 64'h0);
        v_i = 1'b0;
        rst_n = 1'b1;

        // Full-word CSR write and read-back.
        req(1'b1, 32'h4, 2'b10, 32'hA5A5A5A5, 32'h0, "csr1_wr_rdata");
        req(1'b0, 32'h4, 2'b10, 32'h0, 32'hA5A5A5A5, "csr1_rd");
        wait_idle("csr1");
        chk("csr_o_w1", 64'(csr_o[63:32]), 64'hA5A5A5A5);

        // Byte, halfword and clipped doubleword lane writes.
        req(1'b1, 32'h0, 2'b10, 32'h11223344, 32'h0, "csr0_wr");
        req(1'b1, 32'h2, 2'b00, 32'h000000FF, 32'h0, "csr0_byte_wr");
        req(1'b0, 32'h0, 2'b10, 32'h0, 32'h11FF3344, "csr0_rd_byte");
        req(1'b1, 32'h1, 2'b01, 32'h0000BEEF, 32'h0, "csr0_half_wr");
        req(1'b0, 32'h0, 2'b10, 32'h0, 32'h11BEEF44, "csr0_rd_half");
        req(1'b1, 32'hE, 2'b11, 32'hAABBCCDD, 32'h0, "csr3_clip_wr");
        req(1'b0, 32'hC, 2'b10, 32'h0, 32'hCCDD0000, "csr3_rd_clip");

        // Writes to status, unmapped and far addresses must not touch the CSRs.
        req(1'b1, 32'h18, 2'b10, 32'hFFFFFFFF, 32'h0, "status_wr");
        req(1'b0, 32'h18, 2'b10, 32'h0, 32'h0, "status_idle");
        req(1'b1, 32'h1C, 2'b10, 32'hDEADBEEF, 32'h0, "unmapped_wr");
        req(1'b0, 32'h1C, 2'b10, 32'h0, 32'h0, "unmapped_rd");
        req(1'b1, 32'h80000004, 2'b10, 32'h00000BAD, 32'h0, "far_wr");
        wait_idle("lanes");
        chk("csr_o_w0", 64'(csr_o[31:0]), 64'h11BEEF44);
        chk("csr_o_w1_kept", 64'(csr_o[63:32]), 64'hA5A5A5A5);
        chk("csr_o_w3", 64'(csr_o[127:96]), 64'hCCDD0000);

        // OUT FIFO: fill to full, check blocking, pop one, refill.
        for (int i = 0; i < 4; i++) begin
            req(1'b1, 32'h10, 2'b10, 32'h100 + i, 32'h0, $sformatf("out_push%0d", i));
        end
        req(1'b0, 32'h18, 2'b10, 32'h0, 32'h4, "status_out4");
        req(1'b0, 32'h10, 2'b10, 32'h0, 32'h0, "out_rd_zero");
        wait_idle("out_fill");
        @(negedge clk);
        v_i = 1'b1; wr_en_i = 1'b1; addr_i = 32'h10; data_size_i = 2'b00; wdata_i = 32'h104;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("out_full_block%0d", i), 64'(ready_and_o), 64'h0);
            @(negedge clk);
        end
        v_i = 1'b0;
        chk("out_v_full", 64'(out_v_o), 64'h1);
        chk("out_head", 64'(out_data_o), 64'h100);
        out_ready_and_i = 1'b1;
        @(posedge clk);
        #1;
        out_ready_and_i = 1'b0;
        req(1'b0, 32'h18, 2'b10, 32'h0, 32'h3, "status_out3");
        req(1'b1, 32'h10, 2'b00, 32'h104, 32'h0, "out_push_bytesize");
        req(1'b0, 32'h18, 2'b10, 32'h0, 32'h4, "status_out4b");
        wait_idle("out_refill");
        out_ready_and_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain_v%0d", i), 64'(out_v_o), 64'h1);
            chk($sformatf("drain_data%0d", i), 64'(out_data_o), 64'h100 + 64'(i));
            @(negedge clk);
        end
        chk("drain_empty", 64'(out_v_o), 64'h0);
        out_ready_and_i = 1'b0;

        // IN FIFO: empty read, single word, then fill to full and drain.
        req(1'b0, 32'h14, 2'b10, 32'h0, 32'h0, "in_rd_empty");
        req(1'b0, 32'h18, 2'b10, 32'h0, 32'h0, "status_in0");
        wait_idle("in_empty");
        in_if.v = 1'b1; in_if.data = 32'h55;
        #1;
        chk("in_ready_empty", 64'(in_if.ready_and), 64'h1);
        @(posedge clk);
        #1;
        in_if.v = 1'b0;
        req(1'b0, 32'h18, 2'b10, 32'h0, 32'h100, "status_in1");
        req(1'b0, 32'h14, 2'b10, 32'h0, 32'h55, "in_rd");
        req(1'b0, 32'h18, 2'b10, 32'h0, 32'h0, "status_in0b");
        wait_idle("in_single");
        in_if.v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_if.data = 32'h60 + i;
            @(posedge clk);
            #1;
        end
        in_if.v = 1'b0;
        @(negedge clk);
        chk("in_ready_full", 64'(in_if.ready_and), 64'h0);
        req(1'b1, 32'h14, 2'b10, 32'h99, 32'h0, "in_wr_ignored");
        req(1'b0, 32'h18, 2'b10, 32'h0, 32'h400, "status_in4");
        for (int i = 0; i < 4; i++) begin
            req(1'b0, 32'h14, 2'b10, 32'h0, 32'h60 + i, $sformatf("in_pop%0d", i));
        end
        req(1'b0, 32'h18, 2'b10, 32'h0, 32'h0, "status_in_drained");
        wait_idle("in_full");

        // Stalled response: held stable, no new acceptance.
        ready_and_i = 1'b0;
        req(1'b0, 32'h4, 2'b10, 32'h0, 32'hA5A5A5A5, "csr1_rd_stall");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall_v%0d", i), 64'(v_o), 64'h1);
            chk($sformatf("stall_rdata%0d", i), 64'(rdata_o), 64'hA5A5A5A5);
            chk($sformatf("stall_ready%0d", i), 64'(ready_and_o), 64'h0);
        end
        @(posedge clk);
        #1;
        ready_and_i = 1'b1;
        wait_idle("stall");

        // Reset in the middle of a pending response with both FIFOs occupied.
        req(1'b1, 32'h10, 2'b10, 32'h200, 32'h0, "pre_rst_out0");
        req(1'b1, 32'h10, 2'b10, 32'h201, 32'h0, "pre_rst_out1");
        req(1'b1, 32'h8, 2'b10, 32'h12345678, 32'h0, "csr2_wr");
        wait_idle("pre_rst");
        in_if.v = 1'b1; in_if.data = 32'h80;
        @(posedge clk);
        #1;
        in_if.v = 1'b0;
        ready_and_i = 1'b0;
        req(1'b0, 32'h8, 2'b10, 32'h0, 32'h12345678, "csr2_rd_discarded");
        @(negedge clk);
        chk("pre_rst_v_o", 64'(v_o), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_v_o", 64'(v_o), 64'h0);
        chk("mid_rst_rdata", 64'(rdata_o), 64'h0);
        chk("mid_rst_out_v", 64'(out_v_o), 64'h0);
        chk("mid_rst_in_ready", 64'(in_if.ready_and), 64'h1);
        chk("mid_rst_csr", 64'(|csr_o), 64'h0);
        chk("mid_rst_ready_and", 64'(ready_and_o), 64'h0);
        exp_q.delete();
        tag_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        ready_and_i = 1'b1;
        req(1'b0, 32'h18, 2'b10, 32'h0, 32'h0, "status_post_rst");
        req(1'b0, 32'h8, 2'b10, 32'h0, 32'h0, "csr2_post_rst");
        wait_idle("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
